block_b_table_arb: RTL and testbench

//  Shares the single blockBTable1 memory port between the blockB register block (APB path) and a hardware lookup/update requester.
//  The register path has absolute priority; the hardware path gets a req/gnt handshake and a 1-cycle-latency read return.

---
 rtl/block_b_table_arb_if.sv | 56 +++++
 rtl/block_b_table_arb.sv | 147 ++++++++++++++
 tb/tb_block_b_table_arb.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_b_table_arb_if.sv
// Bundle of the three buses that meet at the blockBTable1 arbiter:
// the register-block access port, the hardware lookup/update requester,
// and the single shared memory port.
// slave  : the arbiter's view.
// master : the environment's view (register block, requester and memory together).
interface block_b_table_arb_if #(
  parameter int AW = 4,
  parameter int DW = 5
);
  // Register-block side
  logic          reg_en;
  logic          reg_wr;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;

  // Hardware requester side
  logic          hw_req;
  logic          hw_wr;
  logic [AW-1:0] hw_addr;
  logic [DW-1:0] hw_wdata;
  logic          hw_gnt;
  logic          hw_rvalid;
  logic [DW-1:0] hw_rdata;
  logic          hw_err;

  // Shared memory port
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Table ready
  logic          init_done;

  modport slave (
    input  reg_en, reg_wr, reg_addr, reg_wdata,
    output reg_rdata,
    input  hw_req, hw_wr, hw_addr, hw_wdata,
    output hw_gnt, hw_rvalid, hw_rdata, hw_err,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata,
    output init_done
  );

  modport master (
    output reg_en, reg_wr, reg_addr, reg_wdata,
    input  reg_rdata,
    output hw_req, hw_wr, hw_addr, hw_wdata,
    input  hw_gnt, hw_rvalid, hw_rdata, hw_err,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata,
    input  init_done
  );
endinterface

// File: rtl/block_b_table_arb.sv
// block_b_table_arb: shares the single blockBTable1 memory port between the
// blockB register block and a hardware lookup/update requester.
//  - Slot priority each cycle: register access > init write > hardware request.
//  - The register side never stalls; the hardware side uses a req/gnt handshake.
//  - Read data (1-cycle memory latency) is steered back to the side that issued the read.
//  - Hardware addresses >= DEPTH are granted without touching memory and answered with hw_err.
// Optional feature: define BLOCKB_TBL_INIT_EN to clear the whole table after reset
// (hardware grants held off until init_done). Without it init_done is 1 from reset
// and the table contents are undefined until written.
module block_b_table_arb #(
  parameter int DEPTH = 10,
  parameter int AW    = 4,
  parameter int DW    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  block_b_table_arb_if.slave    bus
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_REG,
    OWN_HW
  } owner_t;

  owner_t        rd_owner;
  owner_t        rd_owner_nxt;
  logic          err_q;
  logic          err_nxt;
  logic          err_rd_q;
  logic          err_rd_nxt;
  logic          hw_bad;
  logic          init_slot;
  logic          init_done;
  logic [AW-1:0] init_addr;

  assign hw_bad = ({1'b0, bus.hw_addr} >= DEPTH_W);

`ifdef BLOCKB_TBL_INIT_EN
  localparam logic [AW-1:0] INIT_LAST = AW'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] init_cnt;
  logic [AW-1:0] init_cnt_nxt;

  // Init sequencer state and clear pointer.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Advance the clear pointer only in cycles the register side leaves free.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    if (state == S_INIT && !bus.reg_en) begin
      if (init_cnt == INIT_LAST) begin
        state_nxt = S_RUN;
      end else begin
        init_cnt_nxt = init_cnt + 1'b1;
      end
    end
  end

  // Keep the memory port quiet while reset is held; a register write that lands
  // ahead of init_cnt is later overwritten by the clear.
  assign init_slot = (state == S_INIT) && !rst;
  assign init_addr = init_cnt;
  assign init_done = (state == S_RUN);
`else
  assign init_slot = 1'b0;
  assign init_addr = '0;
  assign init_done = 1'b1;
`endif

  // Slot arbitration: pick the single owner of the memory port and grant the requester.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.hw_gnt    = 1'b0;
    rd_owner_nxt  = OWN_NONE;
    err_nxt       = 1'b0;
    err_rd_nxt    = 1'b0;
    if (bus.reg_en) begin
      bus.mem_en    = 1'b1;
      bus.mem_wr    = bus.reg_wr;
      bus.mem_addr  = bus.reg_addr;
      bus.mem_wdata = bus.reg_wdata;
      if (!bus.reg_wr) rd_owner_nxt = OWN_REG;
    end else if (init_slot) begin
      bus.mem_en    = 1'b1;
      bus.mem_wr    = 1'b1;
      bus.mem_addr  = init_addr;
      bus.mem_wdata = '0;
    end else if (bus.hw_req && init_done) begin
      bus.hw_gnt = 1'b1;
      if (hw_bad) begin
        err_nxt    = 1'b1;
        err_rd_nxt = !bus.hw_wr;
      end else begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = bus.hw_wr;
        bus.mem_addr  = bus.hw_addr;
        bus.mem_wdata = bus.hw_wdata;
        if (!bus.hw_wr) rd_owner_nxt = OWN_HW;
      end
    end
  end

  // Remember who issued this cycle's read (and any address error) for the return cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner <= OWN_NONE;
      err_q    <= 1'b0;
      err_rd_q <= 1'b0;
    end else begin
      rd_owner <= rd_owner_nxt;
      err_q    <= err_nxt;
      err_rd_q <= err_rd_nxt;
    end
  end

  // Return path: only the owning side sees memory data, the other holds 0.
  assign bus.reg_rdata = (rd_owner == OWN_REG) ? bus.mem_rdata : '0;
  assign bus.hw_rdata  = (rd_owner == OWN_HW)  ? bus.mem_rdata : '0;
  assign bus.hw_rvalid = (rd_owner == OWN_HW) || err_rd_q;
  assign bus.hw_err    = err_q;
  assign bus.init_done = init_done;

endmodule

// File: tb/tb_block_b_table_arb.sv
// Self-checking bench for block_b_table_arb. Provides the external table
// memory (1-cycle read latency) and keeps an independent shadow of the table
// contents, updated from the stimulus in issue order, to predict every return.
// Build with or without BLOCKB_TBL_INIT_EN; expectations follow the build.
module tb_block_b_table_arb;
  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int DW    = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] mem   [DEPTH];

  always #5 clk = ~clk;

  block_b_table_arb_if #(.AW(AW), .DW(DW)) bus ();

  block_b_table_arb #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External table memory
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic idle();
    bus.reg_en    = 1'b0;
    bus.reg_wr    = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    bus.hw_req    = 1'b0;
    bus.hw_wr     = 1'b0;
    bus.hw_addr   = '0;
    bus.hw_wdata  = '0;
  endtask

  task automatic test_reset();
    logic exp_done;
`ifdef BLOCKB_TBL_INIT_EN
    exp_done = 1'b0;
`else
    exp_done = 1'b1;
`endif
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); end
    n_tests++; if (bus.hw_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_hw_gnt: got %b want 0", bus.hw_gnt); end
    n_tests++; if (bus.hw_rvalid !== 1'b0 || bus.hw_err !== 1'b0) begin n_fail++; $display("FAIL reset_hw_out: rvalid %b err %b want 0 0", bus.hw_rvalid, bus.hw_err); end
    n_tests++; if (bus.reg_rdata !== '0) begin n_fail++; $display("FAIL reset_reg_rdata: got %h want 0", bus.reg_rdata); end
    n_tests++; if (bus.init_done !== exp_done) begin n_fail++; $display("FAIL reset_init_done: got %b want %b", bus.init_done, exp_done); end
  endtask

  // Release reset; with init the table is cleared one entry per cycle and a
  // waiting hardware read is only granted once init_done rises.
  task automatic test_init();
    @(negedge clk);
    rst = 1'b0;
`ifdef BLOCKB_TBL_INIT_EN
    bus.hw_req  = 1'b1;
    bus.hw_wr   = 1'b0;
    bus.hw_addr = AW'(7);
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++;
      if (bus.mem_en !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_addr !== AW'(i) || bus.mem_wdata !== '0) begin
        n_fail++;
        $display("FAIL init_write[%0d]: en %b wr %b addr %0d data %h want 1 1 %0d 0", i, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, i);
      end
      n_tests++;
      if (bus.hw_gnt !== 1'b0 || bus.init_done !== 1'b0) begin
        n_fail++;
        $display("FAIL init_hold[%0d]: gnt %b done %b want 0 0", i, bus.hw_gnt, bus.init_done);
      end
      @(negedge clk);
      #1;
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    n_tests++; if (bus.init_done !== 1'b1) begin n_fail++; $display("FAIL init_done_cycle11: got %b want 1", bus.init_done); end
    n_tests++; if (bus.hw_gnt !== 1'b1) begin n_fail++; $display("FAIL init_first_gnt: got %b want 1", bus.hw_gnt); end
    @(negedge clk);
    idle();
    #1;
    n_tests++; if (bus.hw_rvalid !== 1'b1 || bus.hw_rdata !== '0) begin n_fail++; $display("FAIL init_cleared_read: rvalid %b data %h want 1 0", bus.hw_rvalid, bus.hw_rdata); end
`else
    #1;
    n_tests++; if (bus.init_done !== 1'b1 || bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL noinit_idle: done %b en %b want 1 0", bus.init_done, bus.mem_en); end
`endif
  endtask

  // Load every entry through the register side so the shadow is fully known.
  task automatic test_reg_fill();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      idle();
      bus.reg_en    = 1'b1;
      bus.reg_wr    = 1'b1;
      bus.reg_addr  = AW'(a);
      bus.reg_wdata = DW'($urandom);
      model[a]      = bus.reg_wdata;
      #1;
      n_tests++;
      if (bus.mem_en !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_addr !== AW'(a) || bus.mem_wdata !== model[a]) begin
        n_fail++;
        $display("FAIL reg_passthru[%0d]: en %b wr %b addr %0d data %h want 1 1 %0d %h", a, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, a, model[a]);
      end
    end
    @(negedge clk);
    idle();
  endtask

  // Register write followed by a hardware read of the same entry returns the new data.
  task automatic test_write_then_read();
    @(negedge clk);
    bus.reg_en    = 1'b1;
    bus.reg_wr    = 1'b1;
    bus.reg_addr  = AW'(3);
    bus.reg_wdata = 5'h15;
    model[3]      = 5'h15;
    @(negedge clk);
    idle();
    bus.hw_req  = 1'b1;
    bus.hw_addr = AW'(3);
    #1;
    n_tests++; if (bus.hw_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_rd_gnt: got %b want 1", bus.hw_gnt); end
    @(negedge clk);
    idle();
    #1;
    n_tests++; if (bus.hw_rvalid !== 1'b1 || bus.hw_rdata !== 5'h15) begin n_fail++; $display("FAIL wr_rd_data: rvalid %b data %h want 1 15", bus.hw_rvalid, bus.hw_rdata); end
    n_tests++; if (bus.reg_rdata !== '0) begin n_fail++; $display("FAIL wr_rd_reg_quiet: got %h want 0", bus.reg_rdata); end
  endtask

  // Register read collides with a held hardware read: register wins, hardware retries.
  task automatic test_conflict();
    @(negedge clk);
    bus.reg_en   = 1'b1;
    bus.reg_wr   = 1'b0;
    bus.reg_addr = AW'(5);
    bus.hw_req   = 1'b1;
    bus.hw_wr    = 1'b0;
    bus.hw_addr  = AW'(2);
    #1;
    n_tests++; if (bus.hw_gnt !== 1'b0 || bus.mem_addr !== AW'(5)) begin n_fail++; $display("FAIL conflict_gnt: gnt %b addr %0d want 0 5", bus.hw_gnt, bus.mem_addr); end
    @(negedge clk);
    bus.reg_en   = 1'b0;
    bus.reg_addr = '0;
    #1;
    n_tests++; if (bus.reg_rdata !== model[5] || bus.hw_rvalid !== 1'b0) begin n_fail++; $display("FAIL conflict_reg_ret: data %h rvalid %b want %h 0", bus.reg_rdata, bus.hw_rvalid, model[5]); end
    n_tests++; if (bus.hw_gnt !== 1'b1) begin n_fail++; $display("FAIL conflict_retry_gnt: got %b want 1", bus.hw_gnt); end
    @(negedge clk);
    idle();
    #1;
    n_tests++; if (bus.hw_rvalid !== 1'b1 || bus.hw_rdata !== model[2] || bus.reg_rdata !== '0) begin n_fail++; $display("FAIL conflict_hw_ret: rvalid %b hw %h reg %h want 1 %h 0", bus.hw_rvalid, bus.hw_rdata, bus.reg_rdata, model[2]); end
  endtask

  // Out-of-range hardware addresses: granted, no memory access, error next cycle.
  task automatic test_bad_addr();
    @(negedge clk);
    bus.hw_req   = 1'b1;
    bus.hw_wr    = 1'b1;
    bus.hw_addr  = AW'(12);
    bus.hw_wdata = DW'($urandom);
    #1;
    n_tests++; if (bus.hw_gnt !== 1'b1 || bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL bad_wr_issue: gnt %b en %b want 1 0", bus.hw_gnt, bus.mem_en); end
    @(negedge clk);
    bus.hw_wr   = 1'b0;
    bus.hw_addr = AW'(10);
    #1;
    n_tests++; if (bus.hw_err !== 1'b1 || bus.hw_rvalid !== 1'b0) begin n_fail++; $display("FAIL bad_wr_err: err %b rvalid %b want 1 0", bus.hw_err, bus.hw_rvalid); end
    n_tests++; if (bus.hw_gnt !== 1'b1 || bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL bad_rd_issue: gnt %b en %b want 1 0", bus.hw_gnt, bus.mem_en); end
    @(negedge clk);
    idle();
    #1;
    n_tests++; if (bus.hw_err !== 1'b1 || bus.hw_rvalid !== 1'b1 || bus.hw_rdata !== '0) begin n_fail++; $display("FAIL bad_rd_err: err %b rvalid %b data %h want 1 1 0", bus.hw_err, bus.hw_rvalid, bus.hw_rdata); end
    @(negedge clk);
    #1;
    n_tests++; if (bus.hw_err !== 1'b0 || bus.hw_rvalid !== 1'b0) begin n_fail++; $display("FAIL bad_err_clear: err %b rvalid %b want 0 0", bus.hw_err, bus.hw_rvalid); end
  endtask

  // Randomised mix of register and hardware traffic; a refused hardware request
  // is held unchanged until granted.
  task automatic test_random_mix();
    logic          r_en, r_wr, h_req, h_wr, pend, gnt, bad;
    logic [AW-1:0] r_addr, h_addr;
    logic [DW-1:0] r_wd, h_wd;
    logic [DW-1:0] exp_reg, exp_hw;
    logic          exp_rv, exp_err;
    pend = 1'b0; h_req = 1'b0; h_wr = 1'b0; h_addr = '0; h_wd = '0;
    exp_reg = '0; exp_hw = '0; exp_rv = 1'b0; exp_err = 1'b0;
    for (int it = 0; it <= 40; it++) begin
      @(negedge clk);
      if (it > 0) begin
        #1;
        n_tests++;
        if (bus.reg_rdata !== exp_reg || bus.hw_rvalid !== exp_rv || bus.hw_rdata !== exp_hw || bus.hw_err !== exp_err) begin
          n_fail++;
          $display("FAIL mix_return[%0d]: reg %h rv %b hw %h err %b want %h %b %h %b", it, bus.reg_rdata, bus.hw_rvalid, bus.hw_rdata, bus.hw_err, exp_reg, exp_rv, exp_hw, exp_err);
        end
      end
      if (it == 40) begin
        idle();
      end else begin
        r_en   = ($urandom_range(0, 9) < 4);
        r_wr   = ($urandom_range(0, 9) < 3);
        r_addr = AW'($urandom_range(0, DEPTH - 1));
        r_wd   = DW'($urandom);
        if (!pend) begin
          h_req  = ($urandom_range(0, 9) < 7);
          h_wr   = ($urandom_range(0, 9) < 3);
          h_addr = AW'($urandom_range(0, DEPTH + 1));
          h_wd   = DW'($urandom);
        end
        bus.reg_en = r_en; bus.reg_wr = r_wr; bus.reg_addr = r_addr; bus.reg_wdata = r_wd;
        bus.hw_req = h_req; bus.hw_wr = h_wr; bus.hw_addr = h_addr; bus.hw_wdata = h_wd;
        gnt = h_req && !r_en;
        bad = (int'(h_addr) >= DEPTH);
        #1;
        n_tests++; if (bus.hw_gnt !== gnt) begin n_fail++; $display("FAIL mix_gnt[%0d]: got %b want %b", it, bus.hw_gnt, gnt); end
        exp_reg = (r_en && !r_wr) ? model[r_addr] : '0;
        exp_rv  = gnt && !h_wr;
        exp_hw  = (gnt && !h_wr && !bad) ? model[h_addr] : '0;
        exp_err = gnt && bad;
        if (r_en && r_wr)              model[r_addr] = r_wd;
        else if (gnt && h_wr && !bad)  model[h_addr] = h_wd;
        pend = h_req && r_en;
      end
    end
  endtask

  // Consecutive hardware reads: one grant and one return every cycle.
  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [DW-1:0] exp_d;
    exp_d = '0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        #1;
        n_tests++; if (bus.hw_rvalid !== 1'b1 || bus.hw_rdata !== exp_d) begin n_fail++; $display("FAIL b2b_ret[%0d]: rvalid %b data %h want 1 %h", i, bus.hw_rvalid, bus.hw_rdata, exp_d); end
      end
      if (i == 8) begin
        idle();
      end else begin
        a = AW'($urandom_range(0, DEPTH - 1));
        bus.hw_req  = 1'b1;
        bus.hw_wr   = 1'b0;
        bus.hw_addr = a;
        exp_d       = model[a];
        #1;
        n_tests++; if (bus.hw_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, bus.hw_gnt); end
      end
    end
  endtask

  // Reset while a hardware read is in flight: its return is dropped.
  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    bus.hw_req  = 1'b1;
    bus.hw_wr   = 1'b0;
    bus.hw_addr = AW'(4);
    #1;
    n_tests++; if (bus.hw_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt: got %b want 1", bus.hw_gnt); end
    #1;
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    n_tests++; if (bus.hw_rvalid !== 1'b0 || bus.hw_rdata !== '0) begin n_fail++; $display("FAIL rstmid_dropped: rvalid %b data %h want 0 0", bus.hw_rvalid, bus.hw_rdata); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
`ifdef BLOCKB_TBL_INIT_EN
    n_tests++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== '0 || bus.init_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_init_restart: wr %b addr %0d done %b want 1 0 0", bus.mem_wr, bus.mem_addr, bus.init_done); end
    k = 0;
    while (bus.init_done !== 1'b1 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_tests++; if (bus.init_done !== 1'b1 || k != DEPTH) begin n_fail++; $display("FAIL rstmid_init_len: done %b cycles %0d want 1 %0d", bus.init_done, k, DEPTH); end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
`else
    k = 0;
    n_tests++; if (bus.init_done !== 1'b1 || bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_noinit: done %b en %b want 1 0 (k=%0d)", bus.init_done, bus.mem_en, k); end
`endif
    @(negedge clk);
    bus.hw_req  = 1'b1;
    bus.hw_addr = AW'(4);
    #1;
    n_tests++; if (bus.hw_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_regnt: got %b want 1", bus.hw_gnt); end
    @(negedge clk);
    idle();
    #1;
    n_tests++; if (bus.hw_rvalid !== 1'b1 || bus.hw_rdata !== model[4]) begin n_fail++; $display("FAIL rstmid_reread: rvalid %b data %h want 1 %h", bus.hw_rvalid, bus.hw_rdata, model[4]); end
  endtask

  initial begin
    idle();
    bus.mem_rdata = '0;
    test_reset();
    test_init();
    test_reg_fill();
    test_write_then_read();
    test_conflict();
    test_bad_addr();
    test_random_mix();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
